// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and default parameters for the UART
// transmit scheduler. Optional frame timeout: UART_TX_SCHED_TIMEOUT_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_STOP = 2'd2,
        WAIT_END  = 2'd3
    } tx_sched_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_SIZE_DATA      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester / transmitter bundle of the UART transmit scheduler.
// slave: the scheduler side; master: requesters plus transmitter.
interface uart_tx_sched_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int SIZE_DATA = DEF_SIZE_DATA
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           i_req_valid;
    logic [NUM_REQ*SIZE_DATA-1:0] i_req_data;
    logic [NUM_REQ-1:0]           o_req_ready;
    logic                         o_tx_en;
    logic                         o_fifo_empty;
    logic [SIZE_DATA-1:0]         o_tx_data;
    logic                         i_tx_done;
    logic                         o_busy;
    logic [IDX_W-1:0]             o_grant_id;
    logic                         o_timeout;

    modport slave (
        input  i_req_valid, i_req_data, i_tx_done,
        output o_req_ready, o_tx_en, o_fifo_empty, o_tx_data,
               o_busy, o_grant_id, o_timeout
    );

    modport master (
        output i_req_valid, i_req_data, i_tx_done,
        input  o_req_ready, o_tx_en, o_fifo_empty, o_tx_data,
               o_busy, o_grant_id, o_timeout
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted index and wraps to 0 after NUM_REQ-1.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int cand;

    // First active requester in rotated priority order wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(i_last) + i) % NUM_REQ;
            if (!o_any && i_req[cand]) begin
                o_any         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter among NUM_REQ requesters.
// Optional frame timeout: define UART_TX_SCHED_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | no frame; grant a pending requester immediately
// LAUNCH    | one-cycle start strobe to the transmitter
// WAIT_STOP | frame shifting out, waiting for done to rise
// WAIT_END  | stop bit, frame ends when done falls
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int SIZE_DATA      = DEF_SIZE_DATA,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    uart_tx_sched_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    tx_sched_state_t      state, state_nxt;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     grant_id_q;
    logic [SIZE_DATA-1:0] tx_data_q;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 grant_go;
    logic                 frame_end;
    logic                 timeout_hit;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (bus.i_req_valid),
        .i_last  (last_grant),
        .o_grant (arb_grant),
        .o_idx   (arb_idx),
        .o_any   (arb_any)
    );

    assign grant_go  = (state == IDLE) && arb_any;
    assign frame_end = (state == WAIT_END) && !bus.i_tx_done;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] timer_q;

    // Frame watchdog: restarts on launch, runs while waiting on the transmitter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            timer_q <= '0;
        else if (state == LAUNCH)
            timer_q <= '0;
        else if (state == WAIT_STOP || state == WAIT_END)
            timer_q <= timer_q + 1'b1;
    end

    // A genuine frame end in the same cycle takes precedence over the abort.
    assign timeout_hit = (state == WAIT_STOP || state == WAIT_END) &&
                         (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) && !frame_end;
`else
    assign timeout_hit = 1'b0;
`endif

    // State, round-robin pointer, served index and latched byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_id_q <= '0;
            tx_data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_go) begin
                last_grant <= arb_idx;
                grant_id_q <= arb_idx;
                tx_data_q  <= bus.i_req_data[arb_idx*SIZE_DATA +: SIZE_DATA];
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (arb_any) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_STOP;
            WAIT_STOP: begin
                if (timeout_hit)         state_nxt = IDLE;
                else if (bus.i_tx_done)  state_nxt = WAIT_END;
            end
            WAIT_END:  if (frame_end || timeout_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Ready is masked by reset so a held request cannot pulse while in reset.
    assign bus.o_req_ready  = (grant_go && i_rst_n) ? arb_grant : '0;
    assign bus.o_tx_en      = (state == LAUNCH);
    assign bus.o_fifo_empty = (state != LAUNCH);
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_grant_id   = grant_id_q;
    assign bus.o_timeout    = timeout_hit;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a vector table of single frames,
// then reset-in-flight, fairness, done-in-idle and timeout sequences.
module tb_uart_tx_sched;
    import uart_pkg::*;

    logic i_clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_tx_sched_if #(.NUM_REQ(4), .SIZE_DATA(8)) bus ();

    uart_tx_sched #(
        .NUM_REQ        (4),
        .SIZE_DATA      (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  rdy;
        logic [1:0]  id;
        logic [7:0]  tx_byte;
        int          done_cyc;
        bit          mutate;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One whole frame; entered and left mid-cycle while the DUT is in IDLE.
    task automatic do_frame(input vec_t v, input string tag);
        logic ok;
        ok = 1'b1;
        bus.i_req_valid = v.valid;
        bus.i_req_data  = v.data;
        bus.i_tx_done   = 1'b0;
        #1;
        chk({tag, " ready"}, 32'(bus.o_req_ready), 32'(v.rdy));
        chk({tag, " idle busy"}, 32'(bus.o_busy), 32'd0);
        @(posedge i_clk); #1;
        bus.i_req_valid = '0;
        if (v.mutate) bus.i_req_data = {4{8'h3C}};
        chk({tag, " launch tx_en"}, 32'(bus.o_tx_en), 32'd1);
        chk({tag, " launch fifo_empty"}, 32'(bus.o_fifo_empty), 32'd0);
        chk({tag, " launch ready"}, 32'(bus.o_req_ready), 32'd0);
        chk({tag, " tx_data"}, 32'(bus.o_tx_data), 32'(v.tx_byte));
        chk({tag, " grant_id"}, 32'(bus.o_grant_id), 32'(v.id));
        @(posedge i_clk); #1;
        repeat (2) begin
            if (bus.o_tx_data !== v.tx_byte || bus.o_busy !== 1'b1 ||
                bus.o_tx_en !== 1'b0 || bus.o_fifo_empty !== 1'b1 ||
                bus.o_req_ready !== 4'b0) ok = 1'b0;
            @(posedge i_clk); #1;
        end
        bus.i_tx_done = 1'b1;
        repeat (v.done_cyc) begin
            @(negedge i_clk);
            if (bus.o_tx_data !== v.tx_byte || bus.o_busy !== 1'b1 ||
                bus.o_tx_en !== 1'b0) ok = 1'b0;
            @(posedge i_clk); #1;
        end
        bus.i_tx_done = 1'b0;
        #1;
        chk({tag, " busy at done fall"}, 32'(bus.o_busy), 32'd1);
        chk({tag, " data at done fall"}, 32'(bus.o_tx_data), 32'(v.tx_byte));
        @(posedge i_clk); #1;
        chk({tag, " busy after end"}, 32'(bus.o_busy), 32'd0);
        chk({tag, " frame stable"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   cnt;
        vec_t f;

        vecs[0]  = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 8'hA5, 2,  1'b1};
        vecs[1]  = '{4'b1111, 32'h44332211, 4'b0010, 2'd1, 8'h22, 16, 1'b0};
        vecs[2]  = '{4'b1111, 32'h44332211, 4'b0100, 2'd2, 8'h33, 1,  1'b0};
        vecs[3]  = '{4'b1111, 32'h44332211, 4'b1000, 2'd3, 8'h44, 1,  1'b0};
        vecs[4]  = '{4'b1111, 32'h44332211, 4'b0001, 2'd0, 8'h11, 1,  1'b0};
        vecs[5]  = '{4'b0001, 32'h000000F0, 4'b0001, 2'd0, 8'hF0, 3,  1'b1};
        vecs[6]  = '{4'b1001, 32'h9C0000C9, 4'b1000, 2'd3, 8'h9C, 1,  1'b0};
        vecs[7]  = '{4'b0110, 32'h00B6A600, 4'b0010, 2'd1, 8'hA6, 2,  1'b0};
        vecs[8]  = '{4'b0101, 32'h00D500C5, 4'b0100, 2'd2, 8'hD5, 1,  1'b1};
        vecs[9]  = '{4'b0011, 32'h0000E1E0, 4'b0001, 2'd0, 8'hE0, 1,  1'b0};
        vecs[10] = '{4'b1000, 32'h7F000000, 4'b1000, 2'd3, 8'h7F, 4,  1'b0};
        vecs[11] = '{4'b0110, 32'h005A4B00, 4'b0010, 2'd1, 8'h4B, 1,  1'b0};

        rst_n           = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_tx_done   = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset tx_en", 32'(bus.o_tx_en), 32'd0);
        chk("reset fifo_empty", 32'(bus.o_fifo_empty), 32'd1);
        chk("reset busy", 32'(bus.o_busy), 32'd0);
        chk("reset grant_id", 32'(bus.o_grant_id), 32'd0);
        chk("reset tx_data", 32'(bus.o_tx_data), 32'd0);
        chk("reset timeout", 32'(bus.o_timeout), 32'd0);
        @(negedge i_clk);
        rst_n = 1'b1;

        // Done held high while idle must not start or end anything.
        @(posedge i_clk); #1;
        bus.i_tx_done = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge i_clk);
            if (bus.o_busy !== 1'b0 || bus.o_tx_en !== 1'b0 || bus.o_req_ready !== 4'b0) ok = 1'b0;
        end
        chk("done in idle ignored", 32'(ok), 32'd1);
        @(posedge i_clk); #1;
        bus.i_tx_done = 1'b0;

        for (int i = 0; i < 12; i++)
            do_frame(vecs[i], $sformatf("vec%0d", i));

        // Reset while in WAIT_STOP with every requester still pending.
        bus.i_req_valid = 4'b1111;
        bus.i_req_data  = 32'h44332211;
        #1;
        chk("pre-reset ready", 32'(bus.o_req_ready), 32'(4'b0100));
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("pre-reset busy", 32'(bus.o_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", 32'(bus.o_busy), 32'd0);
        chk("mid reset tx_en", 32'(bus.o_tx_en), 32'd0);
        chk("mid reset fifo_empty", 32'(bus.o_fifo_empty), 32'd1);
        chk("mid reset ready", 32'(bus.o_req_ready), 32'd0);
        chk("mid reset tx_data", 32'(bus.o_tx_data), 32'd0);
        chk("mid reset grant_id", 32'(bus.o_grant_id), 32'd0);
        @(negedge i_clk);
        rst_n = 1'b1;

        // Fairness after reset: all four held valid, order 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            f.valid    = 4'b1111;
            f.data     = 32'h44332211;
            f.id       = 2'(k % 4);
            f.rdy      = 4'(1 << (k % 4));
            f.tx_byte  = 8'(8'h11 * ((k % 4) + 1));
            f.done_cyc = 1 + (k % 3);
            f.mutate   = 1'b0;
            do_frame(f, $sformatf("fair%0d", k));
        end

        // Frame whose transmitter never reports done.
        bus.i_req_valid = 4'b1111;
        #1;
        chk("stall ready", 32'(bus.o_req_ready), 32'(4'b0001));
        @(posedge i_clk); #1;
        bus.i_req_valid = 4'b0000;
        cnt = 0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        ok = 1'b0;
        while (cnt < 200 && !ok) begin
            @(posedge i_clk); #1;
            cnt++;
            if (bus.o_timeout === 1'b1) ok = 1'b1;
        end
        chk("timeout seen", 32'(ok), 32'd1);
        chk("timeout latency", 32'(cnt), 32'd64);
        bus.i_req_valid = 4'b1111;
        @(posedge i_clk); #1;
        chk("after timeout timeout low", 32'(bus.o_timeout), 32'd0);
        chk("after timeout busy", 32'(bus.o_busy), 32'd0);
        chk("after timeout ready", 32'(bus.o_req_ready), 32'(4'b0010));
        @(posedge i_clk); #1;
        bus.i_req_valid = 4'b0000;
        chk("after timeout grant_id", 32'(bus.o_grant_id), 32'd1);
`else
        ok = 1'b1;
        repeat (150) begin
            @(posedge i_clk); #1;
            cnt++;
            if (bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b1) ok = 1'b0;
        end
        chk("no timeout, still busy", 32'(ok), 32'd1);
        bus.i_tx_done = 1'b1;
        @(posedge i_clk); #1;
        bus.i_tx_done = 1'b0;
        @(posedge i_clk); #1;
        chk("stall frame end", 32'(bus.o_busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
